// File: rtl/led_pwm_blinker.sv
// -----------------------------------------------------------------------------
// led_pwm_blinker
//   Multi-channel LED driver. A shared prescaler divides the board clock into
//   ticks. Each tick advances a shared phase counter. Each phase wrap toggles a
//   shared blink flag. Every channel independently selects OFF, ON, BLINK or
//   PWM (phase < duty) and drives one registered LED pin.
//
// Ports
//   CLK    in   1         clock, rising edge
//   RESET  in   1         asynchronous reset, active-high
//   WE     in   1         write strobe, one write per cycle
//   WADDR  in   ADDR_W    0..CHANNELS-1 = channel config, CHANNELS = DIV
//   WDATA  in   WIDTH     write data: channel {mode[1:0], duty} or DIV value
//   LED    out  CHANNELS  registered LED drive, bit i = channel i
//   TICK   out  1         registered, one cycle per prescaler terminal count
//   WRAP   out  1         registered, one cycle per phase wrap max->0
// -----------------------------------------------------------------------------
module led_pwm_blinker #(
   parameter  int CHANNELS    = 5,
   parameter  int WIDTH       = 22,
   parameter  int DUTY_W      = 8,
   parameter  int DEFAULT_DIV = 8191,
   localparam int ADDR_W      = $clog2(CHANNELS + 1)
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                WE,
   input  logic [ADDR_W-1:0]   WADDR,
   input  logic [WIDTH-1:0]    WDATA,
   output logic [CHANNELS-1:0] LED,
   output logic                TICK,
   output logic                WRAP
);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_PWM   = 2'b11
   } mode_t;

   localparam logic [DUTY_W-1:0] DUTY_RESET = {1'b1, {(DUTY_W-1){1'b0}}};

   // Shared timebase
   logic [WIDTH-1:0]    r_presc;
   logic [WIDTH-1:0]    r_div;
   logic [DUTY_W-1:0]   r_phase;
   logic                r_blink;

   // Per-channel configuration
   mode_t               r_mode [CHANNELS];
   logic [DUTY_W-1:0]   r_duty [CHANNELS];

   // Registered outputs
   logic [CHANNELS-1:0] r_led;
   logic                r_tick;
   logic                r_wrap;

   logic                w_div_wr;
   logic                w_cfg_wr;
   logic                w_tick;
   logic                w_wrap;
   logic [CHANNELS-1:0] w_led_next;

   assign w_div_wr = WE && (WADDR == ADDR_W'(CHANNELS));
   assign w_cfg_wr = WE && (WADDR <  ADDR_W'(CHANNELS));

   // A DIV write restarts the timebase, so a terminal count coinciding with
   // it must not produce a tick (and hence no wrap or blink toggle either).
   assign w_tick = (r_presc == r_div) && !w_div_wr;
   assign w_wrap = w_tick && (r_phase == '1);

   always_comb begin
      // NOTE: default first so every path assigns every bit; no latch.
      w_led_next = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         case (r_mode[i])
            MODE_OFF:   w_led_next[i] = 1'b0;
            MODE_ON:    w_led_next[i] = 1'b1;
            MODE_BLINK: w_led_next[i] = r_blink;
            MODE_PWM:   w_led_next[i] = (r_phase < r_duty[i]);
            default:    w_led_next[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_presc <= '0;
         r_phase <= '0;
         r_div   <= WIDTH'(DEFAULT_DIV);
         r_blink <= 1'b0;
         r_led   <= '0;
         r_tick  <= 1'b0;
         r_wrap  <= 1'b0;
         // NOTE: the config array is plain flops with defined reset values
         // (mode BLINK, half duty), not a RAM, so it is reset like any register.
         for (int i = 0; i < CHANNELS; i++) begin
            r_mode[i] <= MODE_BLINK;
            r_duty[i] <= DUTY_RESET;
         end
      end else begin
         // NOTE: non-blocking throughout, so LED/TICK/WRAP are computed from
         // the pre-edge counter and config values.
         r_led  <= w_led_next;
         r_tick <= w_tick;
         r_wrap <= w_wrap;

         if (w_div_wr) begin
            r_div   <= WDATA;
            r_presc <= '0;
            r_phase <= '0;
         end else if (w_tick) begin
            r_presc <= '0;
            r_phase <= r_phase + DUTY_W'(1);
         end else begin
            r_presc <= r_presc + WIDTH'(1);
         end

         if (w_wrap) begin
            r_blink <= ~r_blink;
         end

         for (int i = 0; i < CHANNELS; i++) begin
            if (w_cfg_wr && (WADDR == ADDR_W'(i))) begin
               r_mode[i] <= mode_t'(WDATA[DUTY_W+1:DUTY_W]);
               r_duty[i] <= WDATA[DUTY_W-1:0];
            end
         end
      end
   end

   assign LED  = r_led;
   assign TICK = r_tick;
   assign WRAP = r_wrap;

endmodule

// File: tb/tb_led_pwm_blinker.sv
// -----------------------------------------------------------------------------
// tb_led_pwm_blinker
//   Self-checking bench for led_pwm_blinker with default parameters.
//   The reference model tracks the number of edges since the timebase last
//   restarted and derives prescaler position, phase and blink state from that
//   count arithmetically. A negedge process compares LED/TICK/WRAP against it
//   every cycle; directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_led_pwm_blinker;

   localparam int CH     = 5;
   localparam int DEFDIV = 8191;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic        we    = 1'b0;
   logic [2:0]  waddr = '0;
   logic [21:0] wdata = '0;
   logic [4:0]  led;
   logic        tick;
   logic        wrap;

   bit clk_run = 1'b0;
   bit chk_en  = 1'b0;
   int n_checks = 0;
   int n_fail   = 0;

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   led_pwm_blinker dut (
      .CLK   (clk),
      .RESET (rst),
      .WE    (we),
      .WADDR (waddr),
      .WDATA (wdata),
      .LED   (led),
      .TICK  (tick),
      .WRAP  (wrap)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   longint unsigned m_div, m_n;
   bit              m_base;
   bit [1:0]        m_mode [CH];
   int              m_duty [CH];
   logic [4:0]      e_led;
   logic            e_tick, e_wrap;

   always @(posedge clk or posedge rst) begin
      longint unsigned per, ph;
      bit bl;
      if (rst) begin
         m_div  = DEFDIV;
         m_n    = 0;
         m_base = 1'b0;
         for (int i = 0; i < CH; i++) begin
            m_mode[i] = 2'b10;
            m_duty[i] = 128;
         end
         e_led  = '0;
         e_tick = 1'b0;
         e_wrap = 1'b0;
      end else begin
         per = m_div + 1;
         ph  = (m_n / per) % 256;
         bl  = m_base ^ bit'((m_n / (per * 256)) % 2);
         for (int i = 0; i < CH; i++) begin
            case (m_mode[i])
               2'b00:   e_led[i] = 1'b0;
               2'b01:   e_led[i] = 1'b1;
               2'b10:   e_led[i] = bl;
               default: e_led[i] = (ph < longint'(m_duty[i]));
            endcase
         end
         if (we && waddr == 3'(CH)) begin
            e_tick = 1'b0;
            e_wrap = 1'b0;
            m_div  = longint'(wdata);
            m_n    = 0;
            m_base = bl;
         end else begin
            e_tick = ((m_n % per) == m_div);
            e_wrap = (((m_n + 1) % (per * 256)) == 0);
            m_n++;
         end
         if (we && waddr < 3'(CH)) begin
            m_mode[waddr] = wdata[9:8];
            m_duty[waddr] = int'(wdata[7:0]);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_led",  {27'd0, led},  {27'd0, e_led});
         check("model_tick", {31'd0, tick}, {31'd0, e_tick});
         check("model_wrap", {31'd0, wrap}, {31'd0, e_wrap});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wr(input int a, input int d);
      @(posedge clk); #1;
      we = 1'b1; waddr = 3'(a); wdata = 22'(d);
      @(posedge clk); #1;
      we = 1'b0; waddr = '0; wdata = '0;
   endtask

   task automatic wait_wrap(input int max_cyc, input string name);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (wrap !== 1'b1 && k < max_cyc);
      if (wrap !== 1'b1) check(name, {31'd0, wrap}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int cnt, first, hi, hi1, chg, nwrap, bad, kled, kwrap;
      logic [4:0] v;
      logic prev;

      // 1: reset with no clock, then count to the first TICK
      #1 rst = 1'b1;
      #20;
      check("rst_led",  {27'd0, led},  32'd0);
      check("rst_tick", {31'd0, tick}, 32'd0);
      check("rst_wrap", {31'd0, wrap}, 32'd0);
      rst = 1'b0;
      #2;
      chk_en  = 1'b1;
      clk_run = 1'b1;
      cnt = 0; first = 0; hi = 0;
      while (first == 0 && cnt < 9000) begin
         @(negedge clk);
         cnt++;
         if (led != 0) hi++;
         // cycle 1 is the period up to the first edge after release
         if (tick === 1'b1) first = cnt + 1;
      end
      check("first_tick_cycle", first, 32'd8193);
      check("led_low_pre_wrap", hi, 32'd0);

      // 2: DIV=0, ch0 PWM duty 64
      wr(CH, 0);
      wr(0, 'h340);
      wait_wrap(600, "t2_wrap_timeout");
      hi = 0; chg = 0; nwrap = 0; prev = 1'b0;
      for (int k = 1; k <= 256; k++) begin
         @(negedge clk);
         if (led[0]) hi++;
         if (k > 1 && led[0] != prev) chg++;
         prev = led[0];
         if (wrap) nwrap++;
      end
      check("pwm64_high", hi, 32'd64);
      check("pwm64_contig", chg, 32'd1);
      check("pwm64_wraps", nwrap, 32'd1);

      // 3: DIV=1, all BLINK
      wr(CH, 1);
      for (int c = 0; c < CH; c++) wr(c, 'h280);
      wait_wrap(1200, "t3_wrap_timeout");
      @(negedge clk);
      v = led;
      kled = 0; kwrap = 0; bad = 0;
      while (led === v && kled < 1200) begin
         @(negedge clk);
         kled++;
         if (led != 5'h00 && led != 5'h1f) bad++;
         if (wrap && kwrap == 0) kwrap = kled;
      end
      check("blink_lockstep", bad + ((v == 5'h00 || v == 5'h1f) ? 0 : 1), 32'd0);
      check("blink_toggle_period", kled, 32'd512);
      check("blink_toggled", {27'd0, led}, {27'd0, ~v});
      check("blink_wrap_pos", kwrap, 32'd511);

      // 4: DIV=1000, at presc ~900 write DIV=3
      wr(CH, 1000);
      repeat (900) @(posedge clk);
      #1 we = 1'b1; waddr = 3'(CH); wdata = 22'd3;
      @(posedge clk); #1 we = 1'b0; waddr = '0; wdata = '0;
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         check($sformatf("div3_tick_%0d", k), {31'd0, tick}, (k == 4) ? 32'd1 : 32'd0);
      end
      // presc is 0 now; three edges bring it to DIV, then write on the terminal count
      repeat (3) @(posedge clk);
      #1 we = 1'b1; waddr = 3'(CH); wdata = 22'd3;
      @(posedge clk); #1 we = 1'b0; waddr = '0; wdata = '0;
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         check($sformatf("supp_tick_%0d", k), {31'd0, tick}, (k == 4) ? 32'd1 : 32'd0);
      end

      // 5: ON / OFF / out-of-range writes
      wr(1, 'h100);
      @(posedge clk); @(negedge clk);
      check("ch1_on", {31'd0, led[1]}, 32'd1);
      wr(2, 'h100);
      @(posedge clk); @(negedge clk);
      check("ch2_on", {31'd0, led[2]}, 32'd1);
      wr(2, 'h000);
      @(posedge clk); @(negedge clk);
      check("ch2_off", {31'd0, led[2]}, 32'd0);
      wr(CH + 1, 0);
      @(posedge clk); @(negedge clk);
      check("oob_ignored", {30'd0, led[2:1]}, 32'd1);

      // 6: async reset pulse mid-PWM, then duty extremes
      wr(CH, 0);
      wr(0, 'h380);
      repeat (100) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #2;
      check("pulse_led",  {27'd0, led},  32'd0);
      check("pulse_tick", {31'd0, tick}, 32'd0);
      check("pulse_wrap", {31'd0, wrap}, 32'd0);
      #1 rst = 1'b0;
      cnt = 0; first = -1;
      while (first < 0 && cnt <= 8300) begin
         @(negedge clk);
         if (cnt == 2) check("pulse_mode_reset", {31'd0, led[1]}, 32'd0);
         if (tick === 1'b1) first = cnt;
         cnt++;
      end
      check("pulse_first_tick", first, 32'd8192);
      wr(CH, 0);
      wr(0, 'h300);
      wr(1, 'h3ff);
      wait_wrap(600, "t6_wrap_timeout");
      hi = 0; hi1 = 0;
      for (int k = 0; k < 256; k++) begin
         @(negedge clk);
         if (led[0]) hi++;
         if (led[1]) hi1++;
      end
      check("pwm0_high", hi, 32'd0);
      check("pwm255_high", hi1, 32'd255);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
